// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  // requester 0 (cpu memory port)
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;
  // requester 1 (program loader / debug port)
  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;
  // memory side
  logic [DATA_WIDTH-1:0] mem_in;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_in,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_we, mem_addr, mem_data, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_in,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_we, mem_addr, mem_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter / sequencer for a single-port
// synchronous-read data memory. One access in flight at a time:
// IDLE picks a requester, ACCESS drives the memory for one edge,
// RESP captures the read data returned by the memory.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  last_reg, last_next;
  logic                  sel_reg, sel_next;
  logic                  sel_we_reg, sel_we_next;
  logic [1:0]            gnt_reg, gnt_next;
  logic [1:0]            rvalid_reg, rvalid_next;
  logic                  mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_data_reg, mem_data_next;
  logic                  busy_reg;
  logic                  pick;

  // Requester inputs gathered into index-able form so selection is one mux.
  logic [1:0]            req_vec;
  logic [1:0]            we_vec;
  logic [ADDR_WIDTH-1:0] addr_vec [2];
  logic [DATA_WIDTH-1:0] wdata_vec [2];

  assign req_vec      = {bus.req1, bus.req0};
  assign we_vec       = {bus.we1, bus.we0};
  assign addr_vec[0]  = bus.addr0;
  assign addr_vec[1]  = bus.addr1;
  assign wdata_vec[0] = bus.wdata0;
  assign wdata_vec[1] = bus.wdata1;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    sel_next      = sel_reg;
    sel_we_next   = sel_we_reg;
    gnt_next      = 2'b00;
    rvalid_next   = 2'b00;
    mem_we_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    mem_data_next = mem_data_reg;
    pick          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          // A tie goes to whoever was not granted last; a lone request wins outright.
          pick          = (&req_vec) ? ~last_reg : req_vec[1];
          mem_addr_next = addr_vec[pick];
          mem_data_next = wdata_vec[pick];
          mem_we_next   = we_vec[pick];
          gnt_next[pick] = 1'b1;
          last_next     = pick;
          sel_next      = pick;
          sel_we_next   = we_vec[pick];
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        // Writes are done once the memory has sampled them; reads wait for data.
        state_next = sel_we_reg ? IDLE : RESP;
      end
      RESP: begin
        rvalid_next[sel_reg] = 1'b1;
        state_next           = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      sel_reg      <= 1'b0;
      sel_we_reg   <= 1'b0;
      gnt_reg      <= 2'b00;
      rvalid_reg   <= 2'b00;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      sel_reg      <= sel_next;
      sel_we_reg   <= sel_we_next;
      gnt_reg      <= gnt_next;
      rvalid_reg   <= rvalid_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      mem_data_reg <= mem_data_next;
      busy_reg     <= (state_next != IDLE);
    end
  end

  // Per-requester read data; only the selected side captures, the other holds.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    logic [DATA_WIDTH-1:0] rdata_reg;
    // Capture the memory word during RESP for the requester being served.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_reg <= '0;
      end else if (state_reg == RESP && sel_reg == 1'(gi)) begin
        rdata_reg <= bus.mem_in;
      end
    end
  end

  assign bus.gnt0     = gnt_reg[0];
  assign bus.gnt1     = gnt_reg[1];
  assign bus.rvalid0  = rvalid_reg[0];
  assign bus.rvalid1  = rvalid_reg[1];
  assign bus.rdata0   = g_rdata[0].rdata_reg;
  assign bus.rdata1   = g_rdata[1].rdata_reg;
  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_data = mem_data_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, directed scenarios, then two
// independent random requesters. A monitor applies each observed grant to
// a reference memory, queues the expected read result, and checks it when
// rvalid appears.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic          cur_we   [2];
  logic [AW-1:0] cur_addr [2];
  logic [DW-1:0] cur_data [2];
  logic          active   [2];
  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] mem_arr [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 8) return 16'h1234;
    return 16'(a * 257) ^ 16'h5A5A;
  endfunction

  // Synchronous-read memory: samples on the rising edge, data next cycle.
  initial begin
    for (int a = 0; a < 64; a++) mem_arr[a] = init_word(a);
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_data;
      bus.mem_in <= mem_arr[bus.mem_addr];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic drive_req(input int n, input logic r, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (n == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt0"},     32'(bus.gnt0), 0);
    chk({tag, "_gnt1"},     32'(bus.gnt1), 0);
    chk({tag, "_rvalid0"},  32'(bus.rvalid0), 0);
    chk({tag, "_rvalid1"},  32'(bus.rvalid1), 0);
    chk({tag, "_rdata0"},   32'(bus.rdata0), 0);
    chk({tag, "_rdata1"},   32'(bus.rdata1), 0);
    chk({tag, "_mem_we"},   32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(bus.mem_data), 0);
    chk({tag, "_busy"},     32'(bus.busy), 0);
  endtask

  task automatic do_reset();
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_access(input int n, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output int gcyc);
    gcyc = -1;
    cur_we[n] = we; cur_addr[n] = addr; cur_data[n] = data; active[n] = 1'b1;
    drive_req(n, 1'b1, we, addr, data);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((n == 0) ? bus.gnt0 : bus.gnt1) begin
        gcyc = cyc_cnt;
        break;
      end
    end
    if (gcyc < 0) chk($sformatf("gnt%0d_timeout", n), 0, 1);
    @(posedge clk);
    #1;
    drive_req(n, 1'b0, we, addr, data);
    active[n] = 1'b0;
    @(negedge clk);
    if (gcyc >= 0) begin
      chk($sformatf("gnt%0d_one_cycle", n), 32'((n == 0) ? bus.gnt0 : bus.gnt1), 0);
      chk("mem_we_one_cycle", 32'(bus.mem_we), 0);
      chk("busy_after_gnt", 32'(bus.busy), 32'(!we));
    end
    @(posedge clk);
    #1;
  endtask

  // Checks the rvalid0 pulse that follows a read returned by do_access.
  task automatic expect_read0(input logic [DW-1:0] val);
    @(negedge clk);
    chk("dir_rvalid0", 32'(bus.rvalid0), 1);
    chk("dir_rdata0", 32'(bus.rdata0), 32'(val));
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    logic          last_w;
    logic          p0, p1;
    logic [DW-1:0] lr [2];
    logic [DW-1:0] ref_mem [64];
    exp_t          e;
    for (int a = 0; a < 64; a++) ref_mem[a] = init_word(a);
    last_w = 1'b1; p0 = 1'b0; p1 = 1'b0; lr[0] = '0; lr[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete(); q1.delete();
        last_w = 1'b1; p0 = 1'b0; p1 = 1'b0; lr[0] = '0; lr[1] = '0;
      end else begin
        if (bus.gnt0 || bus.gnt1) chk("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 0);
        if (bus.rvalid0 || bus.rvalid1) chk("rvalid_exclusive", 32'(bus.rvalid0 & bus.rvalid1), 0);
        for (int n = 0; n < 2; n++) begin
          logic          g, rv;
          logic [DW-1:0] rd;
          int            qs;
          g  = (n == 0) ? bus.gnt0 : bus.gnt1;
          rv = (n == 0) ? bus.rvalid0 : bus.rvalid1;
          rd = (n == 0) ? bus.rdata0 : bus.rdata1;
          qs = (n == 0) ? q0.size() : q1.size();
          if (rv) begin
            chk($sformatf("rvalid%0d_expected", n), 32'(qs != 0), 1);
            if (qs != 0) begin
              e = (n == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("rdata%0d", n), 32'(rd), 32'(e.data));
              chk($sformatf("rvalid%0d_cycle", n), 32'(cyc_cnt), 32'(e.due));
            end
            lr[n] = rd;
          end else begin
            chk($sformatf("rdata%0d_hold", n), 32'(rd), 32'(lr[n]));
            if (qs != 0) begin
              e = (n == 0) ? q0[0] : q1[0];
              if (e.due < cyc_cnt) begin
                chk($sformatf("rvalid%0d_missing", n), 0, 1);
                if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
              end
            end
          end
          if (g) begin
            chk($sformatf("gnt%0d_requested", n), 32'(active[n]), 1);
            chk($sformatf("mem_we_at_gnt%0d", n), 32'(bus.mem_we), 32'(cur_we[n]));
            chk($sformatf("mem_addr_at_gnt%0d", n), 32'(bus.mem_addr), 32'(cur_addr[n]));
            chk($sformatf("mem_data_at_gnt%0d", n), 32'(bus.mem_data), 32'(cur_data[n]));
            chk("busy_at_gnt", 32'(bus.busy), 1);
            if (p0 && p1) chk("tie_winner", 32'(n), 32'(!last_w));
            last_w = 1'(n);
            if (cur_we[n]) begin
              ref_mem[cur_addr[n]] = cur_data[n];
            end else begin
              e.data = ref_mem[cur_addr[n]];
              e.due  = cyc_cnt + 2;
              if (n == 0) q0.push_back(e); else q1.push_back(e);
            end
          end
        end
        p0 = bus.req0;
        p1 = bus.req1;
      end
    end
  endtask

  initial begin
    int g, ga, gb, base, t0, rel;
    active[0] = 1'b0; active[1] = 1'b0;
    cur_we[0] = 1'b0; cur_we[1] = 1'b0;
    cur_addr[0] = '0; cur_addr[1] = '0;
    cur_data[0] = '0; cur_data[1] = '0;
    fork
      monitor_loop();
    join_none

    // Read of 8 from reset, write of 63 by requester 1, read-back via requester 0.
    do_reset();
    base = cyc_cnt;
    do_access(0, 1'b0, 6'd8, 16'h0000, g);
    chk("t1_gnt0_latency", 32'(g - base), 1);
    expect_read0(16'h1234);
    base = cyc_cnt;
    do_access(1, 1'b1, 6'd63, 16'hBEEF, g);
    chk("t2_gnt1_latency", 32'(g - base), 1);
    do_access(0, 1'b0, 6'd63, 16'h0000, g);
    expect_read0(16'hBEEF);

    // Both requesters holding read requests from reset.
    do_reset();
    t0 = cyc_cnt;
    cur_we[0] = 1'b0; cur_addr[0] = 6'd5; cur_data[0] = '0; active[0] = 1'b1;
    cur_we[1] = 1'b0; cur_addr[1] = 6'd6; cur_data[1] = '0; active[1] = 1'b1;
    drive_req(0, 1'b1, 1'b0, 6'd5, '0);
    drive_req(1, 1'b1, 1'b0, 6'd6, '0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rel = cyc_cnt - t0;
      chk($sformatf("t3_gnt0_rel%0d", rel), 32'(bus.gnt0), 32'(rel == 1 || rel == 7));
      chk($sformatf("t3_gnt1_rel%0d", rel), 32'(bus.gnt1), 32'(rel == 4 || rel == 10));
      chk($sformatf("t3_rvalid0_rel%0d", rel), 32'(bus.rvalid0), 32'(rel == 3 || rel == 9));
      chk($sformatf("t3_rvalid1_rel%0d", rel), 32'(bus.rvalid1), 32'(rel == 6));
    end
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    active[0] = 1'b0; active[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Lone requester 0 reading 8, 9, 10 back to back.
    base = cyc_cnt;
    for (int i = 0; i < 3; i++) begin
      do_access(0, 1'b0, 6'(8 + i), 16'h0000, g);
      chk($sformatf("t4_gnt_cycle%0d", i), 32'(g - base), 32'(1 + 3 * i));
    end
    repeat (2) @(posedge clk);
    #1;

    // Requester 1 raised during the ACCESS cycle of a requester-0 write.
    base = cyc_cnt;
    fork
      do_access(0, 1'b1, 6'd30, 16'hA5A5, ga);
      begin
        @(posedge clk);
        #1;
        do_access(1, 1'b0, 6'd30, 16'h0000, gb);
      end
    join
    chk("t6_gnt0_cycle", 32'(ga - base), 1);
    chk("t6_gnt1_cycle", 32'(gb - base), 3);
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted during RESP of a read, then a tie.
    cur_we[0] = 1'b0; cur_addr[0] = 6'd12; cur_data[0] = '0; active[0] = 1'b1;
    drive_req(0, 1'b1, 1'b0, 6'd12, '0);
    g = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.gnt0) begin
        g = cyc_cnt;
        break;
      end
    end
    chk("t5_gnt0_seen", 32'(g >= 0), 1);
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    active[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_in_resp");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_rvalid0", 32'(bus.rvalid0), 0);
    end
    @(posedge clk);
    #1;
    base = cyc_cnt;
    fork
      do_access(0, 1'b0, 6'd20, 16'h0000, ga);
      do_access(1, 1'b0, 6'd21, 16'h0000, gb);
    join
    chk("t5_tie_gnt0_first", 32'(ga - base), 1);
    chk("t5_tie_gnt1_second", 32'(gb - base), 4);
    repeat (2) @(posedge clk);
    #1;

    // Two independent random requesters.
    fork
      for (int i = 0; i < 30; i++) begin
        int            gap, gr;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        gap = int'($urandom_range(0, 3));
        w   = 1'($urandom_range(0, 1));
        a   = 6'($urandom_range(0, 15));
        d   = 16'($urandom);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        do_access(0, w, a, d, gr);
      end
      for (int j = 0; j < 30; j++) begin
        int            gap, gr;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        gap = int'($urandom_range(0, 3));
        w   = 1'($urandom_range(0, 1));
        a   = 6'($urandom_range(0, 15));
        d   = 16'($urandom);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        do_access(1, w, a, d, gr);
      end
    join

    repeat (6) @(posedge clk);
    #1;
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port, synchronous-read data memory.
- Requester 0 is the cpu memory port; requester 1 is the program loader / debug port.
- Serialises accesses with round-robin arbitration, drives the memory address/data/write-enable lines from registers, and returns read data to the winning requester.
- Sits between the cpu (and loader) and the memory instance in the top level.

Parameters:
- ADDR_WIDTH, 6, memory address width (2^ADDR_WIDTH words).
- DATA_WIDTH, 16, memory word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 access request; held high until gnt0
- we0  in  1  requester 0: 1 write, 0 read; stable while req0 high
- addr0  in  ADDR_WIDTH  requester 0 address
- wdata0  in  DATA_WIDTH  requester 0 write data
- gnt0  out  1  one-cycle pulse: requester 0 access issued
- rvalid0  out  1  one-cycle pulse: rdata0 valid
- rdata0  out  DATA_WIDTH  read data for requester 0; holds until next rvalid0
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above, for requester 1
- mem_in  in  DATA_WIDTH  memory read data, valid the cycle after the access edge
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data  out  DATA_WIDTH  memory write data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - Every output is 0: gnt*, rvalid*, rdata*, mem_we, mem_addr, mem_data, busy.
  - State goes to IDLE and last_grant = 1.
  - Any in-flight access is discarded with no gnt/rvalid; the requester must re-request.
- Registers and outputs: all outputs are registered. Memory samples mem_we/mem_addr/mem_data on the rising edge and presents read data on mem_in during the following cycle.
- State machine: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE; mem_we = 0.
  - Exactly one req: select it.
  - Both reqs: select the requester != last_grant.
  - On selection, at the clock edge:
    - mem_addr <= addrN, mem_data <= wdataN, mem_we <= weN.
    - gntN <= 1, last_grant <= N, latch sel = N and sel_we = weN.
    - Go to ACCESS.
- ACCESS (gntN high this cycle):
  - At the edge: gnt <= 0, mem_we <= 0.
  - sel_we = 1: go to IDLE.
  - sel_we = 0: go to RESP.
  - mem_addr/mem_data hold their last values until the next grant.
- RESP:
  - At the edge: rdata_sel <= mem_in, rvalid_sel <= 1, go to IDLE.
  - rvalid is a one-cycle pulse, high during the following IDLE cycle.
- Latency, with req first seen high in IDLE cycle t:
  - gnt in cycle t+1.
  - Write committed at edge t+2.
  - Read: rvalid and rdata in cycle t+3.
- Throughput: a write every 2 cycles; a read every 3 cycles.
  - A new grant may be issued in the same IDLE cycle in which the previous rvalid is high.
- Requests are sampled only in IDLE.
  - A request raised during ACCESS/RESP waits; it is not lost as long as req stays high.
  - Requester rule: drop req in the cycle after gnt, or re-request for back-to-back access. A req still high in IDLE after gnt is treated as a new request.
- Fairness:
  - Both requesters continuously requesting alternate grants: 0,1,0,1...
  - A lone requester is granted every free IDLE cycle regardless of last_grant.
- Only the selected requester's gnt/rvalid ever pulse; the other side's rdata is unchanged.
- Address and data are passed unmodified (no width conversion); wrap-around is the memory's concern.
- gnt0 and gnt1 are never high simultaneously; same for rvalid0/rvalid1.

Test Plan:
- Reset, then req0=1, we0=0, addr0=6'd8, memory[8]=16'h1234.
  - Required: gnt0 in cycle 1, mem_we=0, mem_addr=8.
  - Required: rvalid0=1 with rdata0=16'h1234 in cycle 3; busy high in cycles 1-2.
- req1=1, we1=1, addr1=6'd63, wdata1=16'hBEEF.
  - Required: gnt1 and mem_we=1, mem_addr=63, mem_data=16'hBEEF for exactly one cycle.
  - Required: later read of 63 via requester 0 returns 16'hBEEF.
- req0 and req1 both held high (reads) from reset for 12 cycles.
  - Required: grant order 0,1,0,1 with one grant every 3 cycles.
  - Required: each rvalid goes only to its own requester.
- req0 held high alone with reads of addresses 8,9,10.
  - Required: grants at cycles 1,4,7; rdata0 matches memory each time; gnt1/rvalid1 stay 0.
- rst_n asserted during RESP of a read.
  - Required: all outputs 0 immediately and no rvalid.
  - Required: after release, first tie goes to requester 0.
- req1 raised during ACCESS of a requester-0 write.
  - Required: gnt1 issued in the cycle after the return to IDLE (cycle 3 relative to gnt0 at cycle 1).
